countdown_timer_core: RTL and testbench

- Parametrised successor to the single-purpose seconds countdown timer behind the KEY/HEX top level.
- Generalises count width and tick rate, and adds down, up and auto-reload modes plus pause/resume.
- A one-cycle expiry pulse is provided.
- Sits between the debounced KEY/SW inputs and the HEX display/LEDR logic of top_level; the top level instantiates one per channel.

---
 rtl/timer_pkg.sv | 57 +++++
 rtl/binary_to_bcd.sv | 34 +++
 rtl/tick_prescaler.sv | 56 +++++
 rtl/countdown_timer_core.sv | 235 +++++++++++++++++++++++
 tb/tb_countdown_timer_core.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types and elaboration-time helpers for countdown_timer_core.
//   timer_mode_t  : counting mode captured on load (DOWN, UP, RELOAD)
//   state_t       : control state of the timer core
//   calc_tick_div : clock cycles per count unit (CLK_HZ / SCALE_FACTOR)
//   calc_ndig     : decimal digits needed to show any WIDTH-bit unsigned value
// -----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        DOWN   = 2'd0,
        UP     = 2'd1,
        RELOAD = 2'd2
    } timer_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A zero scale factor yields 0 so that the caller's range check fires
    // instead of a divide-by-zero during elaboration.
    function automatic int calc_tick_div(input int clk_hz, input int scale_factor);
        if (scale_factor > 0) begin
            return clk_hz / scale_factor;
        end else begin
            return 0;
        end
    endfunction

    // Digit count of the largest WIDTH-bit value, i.e. ceil(WIDTH*log10(2))
    // for WIDTH >= 1. Never returns less than one digit.
    function automatic int calc_ndig(input int width);
        logic [63:0] v;
        int          n;
        v = (64'd1 << width) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                n = n + 1;
                v = v / 64'd10;
            end else begin
                v = v;
            end
        end
        if (n < 1) begin
            n = 1;
        end else begin
            n = n;
        end
        return n;
    endfunction

endpackage

// File: rtl/binary_to_bcd.sv
// -----------------------------------------------------------------------------
// binary_to_bcd
// Combinational double-dabble converter. Only compiled when the optional BCD
// output of countdown_timer_core is enabled with COUNTDOWN_TIMER_BCD_EN.
//   bin_i : WIDTH-bit unsigned binary value
//   bcd_o : NDIG packed BCD digits, least significant digit in bits [3:0]
// -----------------------------------------------------------------------------
`ifdef COUNTDOWN_TIMER_BCD_EN
module binary_to_bcd #(
    parameter int WIDTH = 11,
    parameter int NDIG  = 4
) (
    input  logic [WIDTH-1:0]  bin_i,
    output logic [4*NDIG-1:0] bcd_o
);

    logic [4*NDIG-1:0] acc_s;

    // Shift binary in MSB first; any digit >= 5 is pre-corrected by +3 so the
    // following shift carries correctly into the next decimal digit.
    always_comb begin
        acc_s = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            for (int d = 0; d < NDIG; d++) begin
                acc_s[4*d +: 4] = (acc_s[4*d +: 4] >= 4'd5) ? (acc_s[4*d +: 4] + 4'd3)
                                                            : acc_s[4*d +: 4];
            end
            acc_s = {acc_s[4*NDIG-2:0], bin_i[i]};
        end
        bcd_o = acc_s;
    end

endmodule
`endif

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides the clock into count units of TICK_DIV cycles. The internal count
// only advances while enable_i is high and holds otherwise, so a paused timer
// resumes part-way through the current unit.
//   clk_i    : clock
//   reset_i  : synchronous active-high reset (count -> 0)
//   clear_i  : synchronous clear (count -> 0), used on load
//   enable_i : advance the count this cycle
//   wrap_o   : combinational, high on the enabled cycle that completes a unit
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 10
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic wrap_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    // Unit boundary: last cycle of the unit while advancing.
    always_comb begin
        wrap_o = enable_i && (cnt_q == LAST);
    end

    // Next prescaler value: clear, wrap, advance or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (wrap_o) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + PW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer_core.sv
// -----------------------------------------------------------------------------
// countdown_timer_core
// Parametrised count timer with DOWN, UP and auto-RELOAD modes, pause/resume,
// a one-cycle expiry pulse and a per-unit tick pulse. One instance per channel.
// Optional BCD output enabled by defining COUNTDOWN_TIMER_BCD_EN.
//   clk        : system clock
//   reset      : synchronous active-high reset
//   load       : capture load_value and mode, return to IDLE
//   load_value : start value (DOWN/RELOAD) or target (UP)
//   mode       : 0=DOWN 1=UP 2=RELOAD 3=DOWN, sampled only on load
//   start      : begin/resume counting (IDLE/PAUSE)
//   stop       : pause counting (RUN), wins over start
//   count      : current count
//   running    : high in RUN
//   done       : high in DONE
//   expired    : one-cycle pulse on a terminal event
//   tick       : one-cycle pulse on every unit boundary in RUN
//   bcd        : (COUNTDOWN_TIMER_BCD_EN only) BCD digits of count, one cycle late
// -----------------------------------------------------------------------------
module countdown_timer_core
    import timer_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCALE_FACTOR = 1,
    parameter int WIDTH        = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done,
    output logic             expired,
    output logic             tick
`ifdef COUNTDOWN_TIMER_BCD_EN
    ,
    output logic [4*calc_ndig(WIDTH)-1:0] bcd
`endif
);

    localparam int TICK_DIV = calc_tick_div(CLK_HZ, SCALE_FACTOR);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    generate
        if (TICK_DIV < 1) begin : g_bad_tick_div
            $error("countdown_timer_core: CLK_HZ/SCALE_FACTOR must be at least 1");
        end
    endgenerate

    state_t           state_q, state_d;
    timer_mode_t      mode_q, mode_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             running_q, done_q, expired_q, expired_d, tick_q, tick_d;
    logic             wrap_s;
    logic             presc_en_s;
    logic             terminal_s;

    // Prescaler only advances in RUN on cycles that are not overridden by
    // load or stop, so a stopped unit is resumed exactly where it left off.
    always_comb begin
        presc_en_s = (state_q == RUN) && !load && !stop;
    end

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk_i    (clk),
        .reset_i  (reset),
        .clear_i  (load),
        .enable_i (presc_en_s),
        .wrap_o   (wrap_s)
    );

    // Count already at its end point (used when starting from IDLE).
    always_comb begin
        if (mode_q == UP) begin
            terminal_s = (count_q == target_q);
        end else begin
            terminal_s = (count_q == '0);
        end
    end

    // Next-state, next-count and pulse logic; load > stop > start.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        target_d  = target_q;
        count_d   = count_q;
        expired_d = 1'b0;
        tick_d    = 1'b0;
        if (load) begin
            case (mode)
                2'd1:    mode_d = UP;
                2'd2:    mode_d = RELOAD;
                default: mode_d = DOWN;
            endcase
            target_d = load_value;
            count_d  = (mode == 2'd1) ? '0 : load_value;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        if (terminal_s) begin
                            state_d   = DONE;
                            expired_d = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                PAUSE: begin
                    if (start && !stop) begin
                        state_d = RUN;
                    end else begin
                        state_d = PAUSE;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (wrap_s) begin
                        tick_d = 1'b1;
                        case (mode_q)
                            UP: begin
                                count_d = count_q + ONE;
                                if (count_d >= target_q) begin
                                    count_d   = target_q;
                                    state_d   = DONE;
                                    expired_d = 1'b1;
                                end else begin
                                    state_d = RUN;
                                end
                            end
                            RELOAD: begin
                                if ((count_q == ONE) && (target_q != '0)) begin
                                    count_d   = target_q;
                                    expired_d = 1'b1;
                                end else if (count_q <= ONE) begin
                                    count_d   = '0;
                                    state_d   = DONE;
                                    expired_d = 1'b1;
                                end else begin
                                    count_d = count_q - ONE;
                                end
                            end
                            default: begin
                                // Saturate at zero; reaching zero ends the run.
                                if (count_q <= ONE) begin
                                    count_d   = '0;
                                    state_d   = DONE;
                                    expired_d = 1'b1;
                                end else begin
                                    count_d = count_q - ONE;
                                end
                            end
                        endcase
                    end else begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers; flags follow the next state so they line up
    // with the count shown in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= DOWN;
            target_q  <= '0;
            count_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            target_q  <= target_d;
            count_q   <= count_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
            expired_q <= expired_d;
            tick_q    <= tick_d;
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign done    = done_q;
    assign expired = expired_q;
    assign tick    = tick_q;

`ifdef COUNTDOWN_TIMER_BCD_EN
    localparam int NDIG = calc_ndig(WIDTH);

    logic [4*NDIG-1:0] bcd_s;
    logic [4*NDIG-1:0] bcd_q;

    binary_to_bcd #(
        .WIDTH (WIDTH),
        .NDIG  (NDIG)
    ) u_bcd (
        .bin_i (count_q),
        .bcd_o (bcd_s)
    );

    // BCD register trails the count register by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_q <= '0;
        end else begin
            bcd_q <= bcd_s;
        end
    end

    assign bcd = bcd_q;
`endif

endmodule

// File: tb/tb_countdown_timer_core.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer_core
// Directed scenarios followed by random stimulus, each cycle compared with a
// cycle-count reference model of the timer (CLK_HZ=100, SCALE_FACTOR=10, so a
// count unit lasts 10 clock cycles).
// -----------------------------------------------------------------------------
module tb_countdown_timer_core;

    localparam int W    = 11;
    localparam int TDIV = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] load_value;
    logic [1:0]   mode;
    logic         start;
    logic         stop;
    logic [W-1:0] count;
    logic         running;
    logic         done;
    logic         expired;
    logic         tick;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    int m_count, m_target, m_mode, m_elapsed;
    bit m_running, m_paused, m_done, m_exp, m_tick;

    countdown_timer_core #(
        .CLK_HZ       (100),
        .SCALE_FACTOR (10),
        .WIDTH        (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .mode       (mode),
        .start      (start),
        .stop       (stop),
        .count      (count),
        .running    (running),
        .done       (done),
        .expired    (expired),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One elapsed count unit.
    task automatic model_unit();
        if (m_mode == 1) begin
            m_count++;
            if (m_count == m_target) begin
                m_running = 0; m_done = 1; m_exp = 1;
            end
        end else if (m_mode == 2 && m_count == 1 && m_target != 0) begin
            m_count = m_target;
            m_exp   = 1;
        end else begin
            m_count--;
            if (m_count == 0) begin
                m_running = 0; m_done = 1; m_exp = 1;
            end
        end
    endtask

    // Reference behaviour for one clock edge, from the inputs applied to it.
    task automatic model_edge();
        m_exp  = 0;
        m_tick = 0;
        if (reset) begin
            m_count = 0; m_target = 0; m_mode = 0; m_elapsed = 0;
            m_running = 0; m_paused = 0; m_done = 0;
        end else if (load) begin
            m_mode    = (mode == 2'd3) ? 0 : int'(mode);
            m_target  = int'(load_value);
            m_count   = (m_mode == 1) ? 0 : int'(load_value);
            m_elapsed = 0;
            m_running = 0; m_paused = 0; m_done = 0;
        end else if (m_running) begin
            if (stop) begin
                m_running = 0;
                m_paused  = 1;
            end else begin
                m_elapsed++;
                if (m_elapsed == TDIV) begin
                    m_elapsed = 0;
                    m_tick    = 1;
                    model_unit();
                end
            end
        end else if (!m_done && start && !stop) begin
            if (!m_paused && ((m_mode == 1) ? (m_count == m_target) : (m_count == 0))) begin
                m_done = 1;
                m_exp  = 1;
            end else begin
                m_running = 1;
                m_paused  = 0;
            end
        end
    endtask

    // Advance one clock, update the model, compare all outputs at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("count",   32'(count),   32'(m_count));
        chk("running", 32'(running), 32'(m_running));
        chk("done",    32'(done),    32'(m_done));
        chk("expired", 32'(expired), 32'(m_exp));
        chk("tick",    32'(tick),    32'(m_tick));
    endtask

    task automatic do_load(input int lv, input int md);
        load       = 1'b1;
        load_value = W'(lv);
        mode       = 2'(md);
        cycle();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    int pulses;
    int at;
    int low_run;

    initial begin
        reset = 1'b1; load = 1'b0; load_value = '0; mode = 2'd0; start = 1'b0; stop = 1'b0;
        cycle();
        cycle();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        // DOWN from 10
        do_load(10, 0);
        do_start();
        chk("down_running", 32'(running), 32'd1);
        pulses = 0; at = -1;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (expired) begin pulses++; at = i; end
        end
        chk("down_pulses", 32'(pulses), 32'd1);
        chk("down_exp_at", 32'(at), 32'd99);
        chk("down_count0", 32'(count), 32'd0);
        chk("down_done", 32'(done), 32'd1);
        chk("down_not_running", 32'(running), 32'd0);
        repeat (5) cycle();

        // pause and resume mid-unit
        do_load(10, 0);
        do_start();
        repeat (25) cycle();
        stop = 1'b1; cycle(); stop = 1'b0;
        chk("pause_count", 32'(count), 32'd8);
        chk("pause_running", 32'(running), 32'd0);
        repeat (40) cycle();
        chk("pause_hold", 32'(count), 32'd8);
        do_start();
        at = -1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (tick && at < 0) at = i;
        end
        chk("resume_tick_at", 32'(at), 32'd4);
        chk("resume_count", 32'(count), 32'd7);

        // UP to 3
        do_load(3, 1);
        chk("up_load_count", 32'(count), 32'd0);
        do_start();
        at = -1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (expired) at = i;
        end
        chk("up_exp_at", 32'(at), 32'd29);
        chk("up_count", 32'(count), 32'd3);
        repeat (10) cycle();
        chk("up_hold", 32'(count), 32'd3);
        chk("up_done", 32'(done), 32'd1);

        // RELOAD from 4
        do_load(4, 2);
        do_start();
        pulses = 0; low_run = 0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (expired) pulses++;
            if (!running) low_run++;
        end
        chk("reload_pulses", 32'(pulses), 32'd5);
        chk("reload_low_run", 32'(low_run), 32'd0);
        chk("reload_count", 32'(count), 32'd4);

        // DOWN load 0 then start
        do_load(0, 0);
        do_start();
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_expired", 32'(expired), 32'd1);
        chk("zero_tick", 32'(tick), 32'd0);
        cycle();
        chk("zero_exp_once", 32'(expired), 32'd0);

        // start and stop together in IDLE
        do_load(5, 0);
        start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
        chk("ss_running", 32'(running), 32'd0);
        chk("ss_done", 32'(done), 32'd0);
        cycle();

        // load while running
        do_load(7, 0);
        do_start();
        repeat (20) cycle();
        chk("ldrun_pre", 32'(count), 32'd5);
        do_load(9, 0);
        chk("ldrun_count", 32'(count), 32'd9);
        chk("ldrun_running", 32'(running), 32'd0);
        chk("ldrun_expired", 32'(expired), 32'd0);

        // reset while running, then start at count 0
        do_load(8, 0);
        do_start();
        repeat (20) cycle();
        chk("rstrun_pre", 32'(count), 32'd6);
        reset = 1'b1; cycle(); reset = 1'b0;
        chk("rstrun_count", 32'(count), 32'd0);
        chk("rstrun_running", 32'(running), 32'd0);
        do_start();
        chk("rstrun_done", 32'(done), 32'd1);
        chk("rstrun_expired", 32'(expired), 32'd1);

        // random stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            load       = ($urandom_range(0, 59) == 0);
            load_value = W'($urandom_range(0, 6));
            mode       = 2'($urandom_range(0, 3));
            start      = ($urandom_range(0, 3) == 0);
            stop       = ($urandom_range(0, 19) == 0);
            cycle();
        end
        reset = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
